// File: rtl/activation_code_loader_pkg.sv
// Shared definitions for the activation code loader: FSM state encoding,
// default code geometry and the failed-attempt counter type.
package activation_code_loader_pkg;

  // Default geometry: four 32-bit host words make one 128-bit code.
  localparam int LDR_WORD_W    = 32;
  localparam int LDR_NUM_WORDS = 4;
  localparam int LDR_CODE_W    = LDR_WORD_W * LDR_NUM_WORDS;

  // Failed attempts allowed before permanent lockout (legal 1..15).
  localparam int LDR_MAX_FAILS = 3;

  // Failed-attempt counter; 4 bits covers the whole legal MAX_FAILS range.
  typedef logic [3:0] fail_cnt_t;

  // Loader states. ACCEPTED and LOCKED are only left through reset.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_CHECK    = 3'd2,
    ST_ACCEPTED = 3'd3,
    ST_LOCKED   = 3'd4
  } state_e;

endpackage : activation_code_loader_pkg

// File: rtl/activation_code_loader.sv
// Activation code loader: assembles a code from host words, presents it to
// the comparator only once complete, samples the comparator verdict, counts
// failed attempts and latches either a matching code or a lockout.
module activation_code_loader
  import activation_code_loader_pkg::*;
#(
  parameter int WORD_W    = LDR_WORD_W,
  parameter int NUM_WORDS = LDR_NUM_WORDS,
  parameter int MAX_FAILS = LDR_MAX_FAILS
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic                        wr_valid,
  input  logic [WORD_W-1:0]           wr_data,
  output logic                        wr_ready,
  input  logic                        abort,
  output logic [WORD_W*NUM_WORDS-1:0] activation_code,
  input  logic                        enable_in,
  output logic                        accepted,
  output logic                        locked,
  output logic [3:0]                  fail_count,
  output logic                        busy
);

  localparam int CODE_W = WORD_W * NUM_WORDS;
  // Keep the index at least one bit wide so a single-word build still elaborates.
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t      LAST_IDX   = idx_t'(NUM_WORDS - 1);
  localparam fail_cnt_t FAIL_LIMIT = fail_cnt_t'(MAX_FAILS);

  state_e            state_q;
  idx_t              idx_q;
  logic [CODE_W-1:0] buf_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] buf_d;
  fail_cnt_t         fail_cnt_q;
  fail_cnt_t         fail_cnt_d;
  fail_cnt_t         fail_count_q;
  logic              accepted_q;
  logic              locked_q;
  logic              xfer;

  // Only IDLE and LOAD take words; gated by reset so the reset cycle shows 0.
  assign wr_ready = rst_n & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
  assign xfer     = wr_valid & wr_ready;
  assign busy     = (state_q == ST_LOAD) | (state_q == ST_CHECK);

  assign activation_code = code_q;
  assign accepted        = accepted_q;
  assign locked          = locked_q;
  assign fail_count      = fail_count_q;

  // Incremented failure count used when a check is rejected.
  assign fail_cnt_d = fail_cnt_q + 4'd1;

  // Buffer with the incoming word dropped into the slot selected by the index.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word_slot
    assign buf_d[gi*WORD_W +: WORD_W] =
      (idx_q == idx_t'(gi)) ? wr_data : buf_q[gi*WORD_W +: WORD_W];
  end

  // Loader FSM with registered status outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      buf_q        <= '0;
      code_q       <= '0;
      fail_cnt_q   <= '0;
      fail_count_q <= '0;
      accepted_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      // Status flags trail the state register by one cycle, which gives the
      // two-edge latency from the last word to the visible verdict.
      accepted_q   <= (state_q == ST_ACCEPTED);
      locked_q     <= (state_q == ST_LOCKED);
      fail_count_q <= fail_cnt_q;

      case (state_q)
        ST_IDLE: begin
          // Index is always 0 here, so buf_d carries word 0 in the low slot.
          if (xfer) begin
            buf_q <= buf_d;
            if (NUM_WORDS == 1) begin
              idx_q   <= '0;
              code_q  <= buf_d;
              state_q <= ST_CHECK;
            end else begin
              idx_q   <= idx_t'(1);
              state_q <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          // Abort wins over a word arriving in the same cycle.
          if (abort) begin
            buf_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_IDLE;
          end else if (xfer) begin
            buf_q <= buf_d;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              code_q  <= buf_d;
              state_q <= ST_CHECK;
            end else begin
              idx_q <= idx_q + idx_t'(1);
            end
          end
        end

        ST_CHECK: begin
          // Comparator result is valid for the whole single CHECK cycle.
          if (enable_in) begin
            state_q <= ST_ACCEPTED;
          end else begin
            buf_q      <= '0;
            code_q     <= '0;
            fail_cnt_q <= fail_cnt_d;
            if (fail_cnt_d == FAIL_LIMIT) begin
              state_q <= ST_LOCKED;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_ACCEPTED: begin
          // Hold the matching code so the comparator keeps enable asserted.
          state_q <= ST_ACCEPTED;
        end

        ST_LOCKED: begin
          // Code already cleared on entry; counter stays at the limit.
          state_q <= ST_LOCKED;
        end

        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
          buf_q   <= '0;
          code_q  <= '0;
        end
      endcase
    end
  end

endmodule : activation_code_loader

// File: tb/tb_activation_code_loader.sv
// Self-checking bench for activation_code_loader with a behavioural
// comparator that matches one fixed 128-bit code.
module tb_activation_code_loader;

  localparam logic [127:0] GOOD = 128'h87C0D0FD_94C369FA_1A4B7E7B_C00BD074;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic         clk_in = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_valid = 1'b0;
  logic [31:0]  wr_data = '0;
  logic         wr_ready;
  logic         abort = 1'b0;
  logic [127:0] activation_code;
  logic         enable_in;
  logic         accepted;
  logic         locked;
  logic [3:0]   fail_count;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  // Comparator model: enable when the presented code matches.
  assign enable_in = (activation_code == GOOD);

  activation_code_loader dut (
    .clk_in          (clk_in),
    .rst_n           (rst_n),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .abort           (abort),
    .activation_code (activation_code),
    .enable_in       (enable_in),
    .accepted        (accepted),
    .locked          (locked),
    .fail_count      (fail_count),
    .busy            (busy)
  );

  typedef struct {
    bit           rst_before;
    logic [127:0] code;
    bit           gaps;
    int           exp_nx;
    logic         exp_acc;
    logic [3:0]   exp_fail;
    logic         exp_lock;
    logic [127:0] exp_code;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    abort    = 1'b0;
    #1 chk("rst_cycle_wr_ready", {127'd0, wr_ready}, 128'd0);
    @(posedge clk_in);
    #1;
    chk("rst_code", activation_code, 128'd0);
    chk("rst_accepted", {127'd0, accepted}, 128'd0);
    chk("rst_locked", {127'd0, locked}, 128'd0);
    chk("rst_fail_count", {124'd0, fail_count}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    #1 chk("post_rst_wr_ready", {127'd0, wr_ready}, 128'd1);
  endtask

  // Offer one word for up to 5 cycles; ok reports whether it transferred.
  task automatic xfer_word(input logic [31:0] w, output bit ok);
    bit rdy;
    ok = 1'b0;
    @(negedge clk_in);
    wr_valid = 1'b1;
    wr_data  = w;
    for (int t = 0; t < 5 && !ok; t++) begin
      rdy = wr_ready;
      @(posedge clk_in);
      #1;
      if (rdy) ok = 1'b1;
      else if (t < 4) @(negedge clk_in);
    end
    if (!ok) wr_valid = 1'b0;
  endtask

  // Load a full code least-significant word first; nx counts transfers.
  task automatic load_code(input logic [127:0] code, input bit gaps, output int nx);
    bit ok;
    nx = 0;
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk_in);
      end
      xfer_word(code[k*32 +: 32], ok);
      if (!ok) return;
      nx++;
      if (k < 3) begin
        chk("partial_code_hidden", activation_code, 128'd0);
      end else begin
        chk("check_code", activation_code, code);
        chk("check_busy", {127'd0, busy}, 128'd1);
      end
    end
    @(negedge clk_in);
    wr_valid = 1'b0;
  endtask

  initial begin
    int  nx;
    bit  ok;
    vecs[0] = '{1'b1, GOOD,                 1'b0, 4, 1'b1, 4'd0, 1'b0, GOOD};
    vecs[1] = '{1'b0, ONES,                 1'b0, 0, 1'b1, 4'd0, 1'b0, GOOD};
    vecs[2] = '{1'b1, ONES,                 1'b0, 4, 1'b0, 4'd1, 1'b0, 128'd0};
    vecs[3] = '{1'b0, ONES,                 1'b1, 4, 1'b0, 4'd2, 1'b0, 128'd0};
    vecs[4] = '{1'b0, 128'd0,               1'b1, 4, 1'b0, 4'd3, 1'b1, 128'd0};
    vecs[5] = '{1'b0, GOOD,                 1'b0, 0, 1'b0, 4'd3, 1'b1, 128'd0};
    vecs[6] = '{1'b1, GOOD ^ {1'b1, 127'd0}, 1'b0, 4, 1'b0, 4'd1, 1'b0, 128'd0};
    vecs[7] = '{1'b0, GOOD ^ 128'd1,        1'b1, 4, 1'b0, 4'd2, 1'b0, 128'd0};
    vecs[8] = '{1'b0, GOOD,                 1'b1, 4, 1'b1, 4'd2, 1'b0, GOOD};
    vecs[9] = '{1'b1, GOOD,                 1'b1, 4, 1'b1, 4'd0, 1'b0, GOOD};

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst_before) do_reset();
      load_code(vecs[i].code, vecs[i].gaps, nx);
      chk($sformatf("v%0d_transfers", i), 128'(nx), 128'(vecs[i].exp_nx));
      if (nx == 4) begin
        // One edge after CHECK: verdict not yet visible on accepted.
        @(posedge clk_in);
        #1;
        chk($sformatf("v%0d_acc_latency", i), {127'd0, accepted}, 128'd0);
        chk($sformatf("v%0d_busy_done", i), {127'd0, busy}, 128'd0);
        @(posedge clk_in);
        #1;
      end else begin
        repeat (2) @(posedge clk_in);
        #1;
      end
      chk($sformatf("v%0d_accepted", i), {127'd0, accepted}, {127'd0, vecs[i].exp_acc});
      chk($sformatf("v%0d_fail_count", i), {124'd0, fail_count}, {124'd0, vecs[i].exp_fail});
      chk($sformatf("v%0d_locked", i), {127'd0, locked}, {127'd0, vecs[i].exp_lock});
      chk($sformatf("v%0d_code", i), activation_code, vecs[i].exp_code);
      chk($sformatf("v%0d_wr_ready", i), {127'd0, wr_ready},
          {127'd0, !(vecs[i].exp_acc || vecs[i].exp_lock)});
      $display("vec %0d: xfers=%0d accepted=%0b fail_count=%0d locked=%0b code=%h",
               i, nx, accepted, fail_count, locked, activation_code);
    end

    // Abort after two words, together with a third word offer.
    do_reset();
    xfer_word(GOOD[31:0], ok);
    chk("abort_w0_xfer", {127'd0, ok}, 128'd1);
    xfer_word(GOOD[63:32], ok);
    chk("abort_w1_xfer", {127'd0, ok}, 128'd1);
    @(negedge clk_in);
    wr_valid = 1'b1;
    wr_data  = GOOD[95:64];
    abort    = 1'b1;
    @(posedge clk_in);
    #1;
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_wr_ready", {127'd0, wr_ready}, 128'd1);
    chk("abort_code", activation_code, 128'd0);
    @(negedge clk_in);
    abort    = 1'b0;
    wr_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 chk("abort_fail_count", {124'd0, fail_count}, 128'd0);
    load_code(GOOD, 1'b0, nx);
    chk("abort_reload_xfers", 128'(nx), 128'd4);
    repeat (2) @(posedge clk_in);
    #1;
    chk("abort_reload_accepted", {127'd0, accepted}, 128'd1);
    chk("abort_reload_code", activation_code, GOOD);
    $display("abort seq: accepted=%0b fail_count=%0d code=%h",
             accepted, fail_count, activation_code);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_activation_code_loader

// File: doc/activation_code_loader.md
Name: activation_code_loader

Overview:
- Upstream feeder for the 128-bit activation comparator. Accepts the activation code from the host as NUM_WORDS 32-bit words over a valid/ready write port and assembles them.
- Presents the full code to the comparator only after assembly completes, then samples the comparator's enable result.
- Counts failed attempts and locks out after MAX_FAILS. Once a code matches, it latches it so the comparator's enable stays asserted.

Parameters:
- WORD_W, 32, width of one host write word
- NUM_WORDS, 4, words per code; code width CODE_W = WORD_W*NUM_WORDS = 128
- MAX_FAILS, 3, failed attempts before permanent lockout (until reset); legal range 1..15

Ports:
- clk_in  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- wr_valid  in  1  host word valid
- wr_data  in  WORD_W  host word, least-significant word first
- wr_ready  out  1  loader can accept a word this cycle
- abort  in  1  discard a partially loaded code
- activation_code  out  CODE_W  code driven to comparator
- enable_in  in  1  comparator result (combinational from activation_code)
- accepted  out  1  matching code latched
- locked  out  1  lockout active
- fail_count  out  4  failed attempts so far
- busy  out  1  load or check in progress

Behaviour:
- Reset, when rst_n=0 at a clk_in edge:
  - state=IDLE, word index=0, assembly buffer=0.
  - activation_code=0, fail_count=0, accepted=0, locked=0, busy=0.
  - wr_ready=0 during the reset cycle.
  - Reset mid-load or mid-check discards everything, including a latched accepted code.
- States: IDLE, LOAD, CHECK, ACCEPTED, LOCKED.
- wr_ready=1 only in IDLE and LOAD. A word transfers when wr_valid & wr_ready at the clock edge.
- IDLE:
  - A transfer writes word 0 to buffer bits [WORD_W-1:0] and sets index=1.
  - Next state is LOAD, or CHECK directly if NUM_WORDS=1.
- LOAD:
  - A transfer writes word k to bits [(k+1)*WORD_W-1 : k*WORD_W], then index++.
  - The transfer with index=NUM_WORDS-1 moves to CHECK.
  - busy=1.
- abort in LOAD: buffer and index cleared, return to IDLE, fail_count unchanged.
  - abort has priority over a simultaneous transfer.
  - abort is ignored in IDLE, CHECK, ACCEPTED and LOCKED.
- activation_code is 0 in IDLE and LOAD, so partial codes never reach the comparator. In CHECK and ACCEPTED it equals the assembled buffer. It is registered.
- CHECK lasts exactly one cycle. The comparator output is sampled on the edge ending that cycle, i.e. 1 cycle after the last word transfer:
  - enable_in=1: go to ACCEPTED, accepted=1 next cycle.
  - enable_in=0: fail_count++ and buffer cleared.
    - If the new fail_count == MAX_FAILS, go to LOCKED and set locked=1.
    - Otherwise go to IDLE.
  - busy=1.
- ACCEPTED: terminal until reset.
  - activation_code holds the matching value; wr_ready=0.
  - Further host writes stall.
- LOCKED: terminal until reset.
  - activation_code=0, wr_ready=0, fail_count saturates at MAX_FAILS.
- Latency: last word accepted at edge N, accepted (or fail_count update) visible after edge N+2.
- A 0 code is legal to submit. Its result depends only on the comparator.

Decomposition:
- Shared package holds:
  - The state enum (IDLE, LOAD, CHECK, ACCEPTED, LOCKED).
  - CODE_W and WORD_W constants, with the default MAX_FAILS.
  - The 4-bit fail-count type.
- No sub-module is needed. The word index counter and the buffer are inline.
- Top-level integration instantiates the loader feeding the comparator: activation_code to the comparator input, comparator enable back to enable_in.

Test Plan:
- Reset, then write 0xC00BD074, 0x1A4B7E7B, 0x94C369FA, 0x87C0D0FD with the real comparator attached:
  - activation_code=0 until the 4th transfer, then 0x87C0D0FD94C369FA1A4B7E7BC00BD074.
  - accepted=1 two edges after the 4th transfer; wr_ready=0 afterwards; the comparator's enable stays 1.
- Write 4 words of 0xFFFFFFFF: fail_count=1, state IDLE, activation_code returns to 0, wr_ready=1. Repeat twice: fail_count=3, locked=1, wr_ready=0.
- After lockout, write the correct code: no transfers accepted, accepted=0, activation_code=0.
- Write 2 words, pulse abort together with a 3rd wr_valid:
  - Third word dropped, index=0, fail_count=0.
  - Then load the correct 4 words: accepted=1.
- Load 2 wrong codes (fail_count=2), then the correct code: accepted=1, fail_count stays 2. Assert rst_n=0 for one cycle: all outputs back to reset values.
- Insert random wr_valid gaps between words: assembled code is identical to the back-to-back case, and each word is captured exactly once.
